// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the stall/flush sequencer: FSM states, PC source
// selects, counter-clear MMIO address and the redirect decision.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEL_PC4     = 2'd0;
    localparam logic [1:0] PC_SEL_ALU     = 2'd1;
    localparam logic [1:0] PC_SEL_RECOVER = 2'd2;
    localparam logic [1:0] PC_SEL_HOLD    = 2'd3;

    localparam logic [31:0] CNT_CLR_ADDR = 32'h8000_0018;

    // Fetch went the wrong way: jumps always redirect, branches redirect when
    // the outcome differs from what fetch assumed (not-taken when bp_en=0).
    function automatic logic redirect_needed(input logic is_br, input logic is_jump,
                                             input logic br_taken, input logic br_pred_taken,
                                             input logic bp_en);
        return is_jump
             | (is_br & bp_en & (br_taken != br_pred_taken))
             | (is_br & !bp_en & br_taken);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Execute-stage flags in, stage controls and counters out. master = core side,
// slave = sequencer. br_cnt/br_mispred_cnt exist only with BP_STATS_EN.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // Flags are sampled combinationally by the sequencer in the same cycle;
    // controls are valid for that cycle and acted on at the next clock edge.
    logic             inst_valid_ex;
    logic             execute_hazard;
    logic             is_br;
    logic             is_jump;
    logic             br_taken;
    logic             br_pred_taken;
    logic             bp_en;
    logic             counter_clr;
    logic             stall_if;
    logic             stall_ex;
    logic             bubble_mem;
    logic             flush_id;
    logic [1:0]       pc_sel;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] inst_cnt;
`ifdef BP_STATS_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] br_mispred_cnt;
`endif
    pipeline_hazard_ctrl_pkg::state_t state;

`ifdef BP_STATS_EN
    modport master (
        output inst_valid_ex, execute_hazard, is_br, is_jump, br_taken, br_pred_taken,
               bp_en, counter_clr,
        input  stall_if, stall_ex, bubble_mem, flush_id, pc_sel, cycle_cnt, inst_cnt,
               br_cnt, br_mispred_cnt, state
    );
    modport slave (
        input  inst_valid_ex, execute_hazard, is_br, is_jump, br_taken, br_pred_taken,
               bp_en, counter_clr,
        output stall_if, stall_ex, bubble_mem, flush_id, pc_sel, cycle_cnt, inst_cnt,
               br_cnt, br_mispred_cnt, state
    );
`else
    modport master (
        output inst_valid_ex, execute_hazard, is_br, is_jump, br_taken, br_pred_taken,
               bp_en, counter_clr,
        input  stall_if, stall_ex, bubble_mem, flush_id, pc_sel, cycle_cnt, inst_cnt,
               state
    );
    modport slave (
        input  inst_valid_ex, execute_hazard, is_br, is_jump, br_taken, br_pred_taken,
               bp_en, counter_clr,
        output stall_if, stall_ex, bubble_mem, flush_id, pc_sel, cycle_cnt, inst_cnt,
               state
    );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Wrapping performance counter; a synchronous clear beats a same-cycle increment.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 3-stage core plus CSR performance counters.
// Define BP_STATS_EN to add the branch and branch-mispredict counters.
module pipeline_hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    import pipeline_hazard_ctrl_pkg::*;

    localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [2:0] down_cnt;
    logic       hazard;
    logic       redirect;
    logic [1:0] redirect_sel;
    logic       stall;
    logic       flush;
    logic [1:0] pc_sel;
    logic       retire;

    assign hazard       = bus.inst_valid_ex & bus.execute_hazard;
    assign redirect     = bus.inst_valid_ex & redirect_needed(bus.is_br, bus.is_jump,
                              bus.br_taken, bus.br_pred_taken, bus.bp_en);
    assign redirect_sel = (bus.is_jump | bus.br_taken) ? PC_SEL_ALU : PC_SEL_RECOVER;

    // RUN decisions are Mealy so the pipeline reacts in the hazard cycle itself.
    always_comb begin
        stall  = 1'b0;
        flush  = 1'b0;
        pc_sel = PC_SEL_PC4;
        case (state)
            RUN: begin
                if (hazard) begin
                    stall  = 1'b1;
                    pc_sel = PC_SEL_HOLD;
                end else if (redirect) begin
                    flush  = 1'b1;
                    pc_sel = redirect_sel;
                end else if (bus.inst_valid_ex & bus.bp_en & bus.is_br
                             & bus.br_pred_taken & bus.br_taken) begin
                    pc_sel = PC_SEL_ALU;
                end
            end
            STALL: begin
                stall  = 1'b1;
                pc_sel = PC_SEL_HOLD;
            end
            FLUSH: begin
                flush = 1'b1;
            end
            default: begin
                stall  = 1'b0;
            end
        endcase
    end

    // down_cnt holds the extra cycles still owed after the first stall/flush cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            down_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        down_cnt <= STALL_LOAD;
                        state    <= (STALL_CYCLES > 1) ? STALL : RUN;
                    end else if (redirect) begin
                        down_cnt <= FLUSH_LOAD;
                        state    <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    end
                end
                STALL, FLUSH: begin
                    if (down_cnt != 3'd0) begin
                        down_cnt <= down_cnt - 3'd1;
                    end
                    if (down_cnt <= 3'd1) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state    <= RUN;
                    down_cnt <= '0;
                end
            endcase
        end
    end

    assign retire = bus.inst_valid_ex & !stall;

    perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .clr   (bus.counter_clr),
        .count (bus.cycle_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_inst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .clr   (bus.counter_clr),
        .count (bus.inst_cnt)
    );

`ifdef BP_STATS_EN
    logic br_mispred;

    assign br_mispred = bus.is_br & (bus.bp_en ? (bus.br_taken != bus.br_pred_taken)
                                               : bus.br_taken);

    perf_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire & bus.is_br),
        .clr   (bus.counter_clr),
        .count (bus.br_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_br_mispred_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire & br_mispred),
        .clr   (bus.counter_clr),
        .count (bus.br_mispred_cnt)
    );
`endif

    assign bus.stall_if   = stall;
    assign bus.stall_ex   = stall;
    assign bus.bubble_mem = stall;
    assign bus.flush_id   = flush;
    assign bus.pc_sel     = pc_sel;
    assign bus.state      = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances (1-cycle stall/2-cycle
// flush and 3-cycle stall/1-cycle flush) driven by the same execute flags.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int CW = 8;

    // {stall_if, stall_ex, bubble_mem, flush_id, pc_sel}
    localparam logic [5:0] O_IDLE   = 6'b000000;
    localparam logic [5:0] O_STALL  = 6'b111011;
    localparam logic [5:0] O_FLREC  = 6'b000110;
    localparam logic [5:0] O_FLALU  = 6'b000101;
    localparam logic [5:0] O_FLONLY = 6'b000100;
    localparam logic [5:0] O_ALU    = 6'b000001;

    logic clk = 1'b0;
    logic rst_n;
    logic valid, haz, br, jmp, taken, pred, bp, clr;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus1 ();
    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus2 ();

    assign bus1.inst_valid_ex  = valid;
    assign bus1.execute_hazard = haz;
    assign bus1.is_br          = br;
    assign bus1.is_jump        = jmp;
    assign bus1.br_taken       = taken;
    assign bus1.br_pred_taken  = pred;
    assign bus1.bp_en          = bp;
    assign bus1.counter_clr    = clr;
    assign bus2.inst_valid_ex  = valid;
    assign bus2.execute_hazard = haz;
    assign bus2.is_br          = br;
    assign bus2.is_jump        = jmp;
    assign bus2.br_taken       = taken;
    assign bus2.br_pred_taken  = pred;
    assign bus2.bp_en          = bp;
    assign bus2.counter_clr    = clr;

    pipeline_hazard_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(CW)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    pipeline_hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(CW)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    logic [5:0] o1, o2;
    assign o1 = {bus1.stall_if, bus1.stall_ex, bus1.bubble_mem, bus1.flush_id, bus1.pc_sel};
    assign o2 = {bus2.stall_if, bus2.stall_ex, bus2.bubble_mem, bus2.flush_id, bus2.pc_sel};

    logic [5:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [CW-1:0] m_cycle, m_inst1, m_inst2, m_br1, m_br2, m_mis1, m_mis2;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        m_cycle = '0; m_inst1 = '0; m_inst2 = '0;
        m_br1 = '0; m_br2 = '0; m_mis1 = '0; m_mis2 = '0;
    endtask

    // Drive one cycle of flags, check the same-cycle outputs of both instances,
    // then advance the counter model for the coming clock edge.
    task automatic step(input string tag, input logic v, input logic h, input logic b,
                        input logic j, input logic t, input logic p, input logic e,
                        input logic c, input logic [5:0] e1, input logic [5:0] e2);
        logic bmis;
        @(negedge clk);
        valid = v; haz = h; br = b; jmp = j; taken = t; pred = p; bp = e; clr = c;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        #2;
        check({tag, "/dut1"}, 32'(o1), 32'(exp_q.pop_front()));
        check({tag, "/dut2"}, 32'(o2), 32'(exp_q.pop_front()));
        bmis = b & (e ? (t != p) : t);
        if (c) begin
            model_clear();
        end else begin
            m_cycle++;
            if (v && !e1[4]) begin
                m_inst1++;
                if (b) m_br1++;
                if (bmis) m_mis1++;
            end
            if (v && !e2[4]) begin
                m_inst2++;
                if (b) m_br2++;
                if (bmis) m_mis2++;
            end
        end
    endtask

    task automatic check_counters(input string tag);
        @(posedge clk);
        #1;
        check({tag, "/cycle1"}, 32'(bus1.cycle_cnt), 32'(m_cycle));
        check({tag, "/cycle2"}, 32'(bus2.cycle_cnt), 32'(m_cycle));
        check({tag, "/inst1"}, 32'(bus1.inst_cnt), 32'(m_inst1));
        check({tag, "/inst2"}, 32'(bus2.inst_cnt), 32'(m_inst2));
`ifdef BP_STATS_EN
        check({tag, "/br1"}, 32'(bus1.br_cnt), 32'(m_br1));
        check({tag, "/br2"}, 32'(bus2.br_cnt), 32'(m_br2));
        check({tag, "/mis1"}, 32'(bus1.br_mispred_cnt), 32'(m_mis1));
        check({tag, "/mis2"}, 32'(bus2.br_mispred_cnt), 32'(m_mis2));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "/out1"}, 32'(o1), 32'(O_IDLE));
        check({tag, "/out2"}, 32'(o2), 32'(O_IDLE));
        check({tag, "/state1"}, 32'(bus1.state), 32'(RUN));
        check({tag, "/state2"}, 32'(bus2.state), 32'(RUN));
        check({tag, "/cycle1"}, 32'(bus1.cycle_cnt), 32'd0);
        check({tag, "/inst2"}, 32'(bus2.inst_cnt), 32'd0);
    endtask

    initial begin
        valid = 0; haz = 0; br = 0; jmp = 0; taken = 0; pred = 0; bp = 0; clr = 0;
        rst_n = 1'b0;
        model_clear();
        #3;
        check_reset_state("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Hazard stall: one cycle on dut1, three on dut2
        step("idle",     0, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  O_IDLE);
        step("plain",    1, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  O_IDLE);
        step("haz",      1, 1, 0, 0, 0, 0, 0, 0, O_STALL, O_STALL);
        step("haz_rel1", 1, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  O_STALL);
        step("haz_rel2", 1, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  O_STALL);
        step("haz_rel3", 1, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  O_IDLE);
        check_counters("cnt_a");

        // Hazard masks a predicted-taken/actually-not-taken branch until release
        step("hz_mis",    1, 1, 1, 0, 0, 1, 1, 0, O_STALL,  O_STALL);
        step("mis_rel",   1, 0, 1, 0, 0, 1, 1, 0, O_FLREC,  O_STALL);
        step("mis_fl",    1, 0, 1, 0, 0, 1, 1, 0, O_FLONLY, O_STALL);
        step("mis_again", 1, 0, 1, 0, 0, 1, 1, 0, O_FLREC,  O_FLREC);
        step("mis_tail",  0, 0, 0, 0, 0, 0, 0, 0, O_FLONLY, O_IDLE);

        // JAL: hazard during dut1's second flush cycle is ignored
        step("jal",     1, 0, 0, 1, 0, 0, 0, 0, O_FLALU,  O_FLALU);
        step("jal_haz", 1, 1, 0, 0, 0, 0, 0, 0, O_FLONLY, O_STALL);
        step("jal_t1",  0, 0, 0, 0, 0, 0, 0, 0, O_IDLE,   O_STALL);
        step("jal_t2",  0, 0, 0, 0, 0, 0, 0, 0, O_IDLE,   O_STALL);
        check_counters("cnt_b");

        // Prediction off, prediction correct, prediction wrong, masked by valid
        step("nbp_taken",   1, 0, 1, 0, 1, 0, 0, 0, O_FLALU,  O_FLALU);
        step("nbp_nt",      1, 0, 1, 0, 0, 0, 0, 0, O_FLONLY, O_IDLE);
        step("nbp_nt2",     1, 0, 1, 0, 0, 0, 0, 0, O_IDLE,   O_IDLE);
        step("pred_ok",     1, 0, 1, 0, 1, 1, 1, 0, O_ALU,    O_ALU);
        step("pred_miss_t", 1, 0, 1, 0, 1, 0, 1, 0, O_FLALU,  O_FLALU);
        step("masked",      0, 0, 1, 0, 1, 0, 1, 0, O_FLONLY, O_IDLE);
        step("masked2",     0, 1, 0, 1, 0, 0, 0, 0, O_IDLE,   O_IDLE);
        check_counters("cnt_c");

        // Three branches after a clear, one of them mispredicted
        step("clr",     0, 0, 0, 0, 0, 0, 0, 1, O_IDLE,   O_IDLE);
        step("br1",     1, 0, 1, 0, 1, 1, 1, 0, O_ALU,    O_ALU);
        step("br2",     1, 0, 1, 0, 0, 0, 1, 0, O_IDLE,   O_IDLE);
        step("br3",     1, 0, 1, 0, 1, 0, 1, 0, O_FLALU,  O_FLALU);
        step("br_tail", 0, 0, 0, 0, 0, 0, 0, 0, O_FLONLY, O_IDLE);
        check_counters("cnt_br");
        check("inst_after_br", 32'(bus1.inst_cnt), 32'd3);
`ifdef BP_STATS_EN
        check("br_cnt_3", 32'(bus1.br_cnt), 32'd3);
        check("br_mispred_1", 32'(bus2.br_mispred_cnt), 32'd1);
`endif

        // Clear wins over a retiring instruction in the same cycle
        step("clr_ret", 1, 0, 0, 0, 0, 0, 0, 1, O_IDLE, O_IDLE);
        check_counters("cnt_clr");
        check("inst_clr_wins", 32'(bus1.inst_cnt), 32'd0);
        check("cycle_clr", 32'(bus2.cycle_cnt), 32'd0);

        // Counter wrap at 2^CW
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            step("wrap_idle", 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE);
        end
        check_counters("cnt_max");
        check("cycle_max", 32'(bus1.cycle_cnt), 32'(8'hFF));
        step("wrap_edge", 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE);
        check_counters("cnt_wrap");
        check("cycle_wrapped", 32'(bus1.cycle_cnt), 32'd0);

        // Reset asserted while dut2 is mid-stall
        step("rs_haz",  1, 1, 0, 0, 0, 0, 0, 0, O_STALL, O_STALL);
        step("rs_hold", 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  O_STALL);
        check("rs_state2", 32'(bus2.state), 32'(STALL));
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        check_reset_state("reset_mid");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("post_rst",  1, 1, 0, 0, 0, 0, 0, 0, O_STALL, O_STALL);
        step("post_rst2", 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  O_STALL);
        check_counters("cnt_post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
